// File: rtl/memory_controller_if.sv
// memory_controller_if: groups the core request/response and external byte-bus signals.
// Latency: none (wiring only).
// Backpressure: requester holds enables until mem_ack; device stretches bus_req via bus_ack.
interface memory_controller_if;
    // Core side
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_dbl_byte_en;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [15:0] mem_data_in;
    logic        mem_ack;
    logic        mem_err;
    // External byte bus side
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    // Controller view
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_dbl_byte_en, cpu_write_en, cpu_read_en,
        input  bus_rdata, bus_ack,
        output mem_data_in, mem_ack, mem_err,
        output bus_addr, bus_wdata, bus_we, bus_req
    );

    // Environment view: core requester plus external device
    modport master (
        output cpu_addr, cpu_wdata, cpu_dbl_byte_en, cpu_write_en, cpu_read_en,
        output bus_rdata, bus_ack,
        input  mem_data_in, mem_ack, mem_err,
        input  bus_addr, bus_wdata, bus_we, bus_req
    );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: bridges 16-bit core requests onto a byte bus, little-endian split, with watchdog.
// Latency: enable->mem_ack 2 cycles (8-bit) / 3 cycles (16-bit) at zero wait, +1 per wait state per byte.
// Backpressure: enables held by requester until mem_ack; bus_req held until bus_ack or watchdog expiry.
module memory_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               nrst,
    memory_controller_if.slave mc
);
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
    localparam bit         WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        dbl_q;
    logic        we_q;
    logic [7:0]  lo_q;
    logic [7:0]  wd_cnt_q;
    logic [15:0] mem_data_q;
    logic        mem_ack_q;
    logic        mem_err_q;
    logic [15:0] bus_addr_q;
    logic [7:0]  bus_wdata_q;
    logic        bus_we_q;
    logic        bus_req_q;

    logic [15:0] addr_hi_d;
    logic        wd_hit_d;

    // Second byte address wraps naturally at 16 bits; watchdog fires once the count reaches the limit
    assign addr_hi_d = addr_q + 16'd1;
    assign wd_hit_d  = WD_EN && (wd_cnt_q == WD_LIMIT);

    // Control FSM; every output is a register updated on the transition into the state that drives it.
    // bus_ack is only looked at in LO/HI, where bus_req is always high, so stray acks are ignored.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            dbl_q       <= 1'b0;
            we_q        <= 1'b0;
            lo_q        <= '0;
            wd_cnt_q    <= '0;
            mem_data_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
        end else begin
            mem_ack_q <= 1'b0;
            mem_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write wins when both enables are high
                    if (mc.cpu_write_en || mc.cpu_read_en) begin
                        addr_q      <= mc.cpu_addr;
                        wdata_q     <= mc.cpu_wdata;
                        dbl_q       <= mc.cpu_dbl_byte_en;
                        we_q        <= mc.cpu_write_en;
                        bus_req_q   <= 1'b1;
                        bus_addr_q  <= mc.cpu_addr;
                        bus_we_q    <= mc.cpu_write_en;
                        bus_wdata_q <= mc.cpu_wdata[7:0];
                        wd_cnt_q    <= '0;
                        state_q     <= LO;
                    end
                end
                LO: begin
                    if (mc.bus_ack) begin
                        lo_q <= mc.bus_rdata;
                        if (dbl_q) begin
                            bus_addr_q  <= addr_hi_d;
                            bus_wdata_q <= wdata_q[15:8];
                            wd_cnt_q    <= '0;
                            state_q     <= HI;
                        end else begin
                            bus_req_q <= 1'b0;
                            mem_ack_q <= 1'b1;
                            if (!we_q) mem_data_q <= {8'h00, mc.bus_rdata};
                            state_q   <= DONE;
                        end
                    end else if (wd_hit_d) begin
                        // Unresponsive device: abandon the access, including any high byte
                        bus_req_q <= 1'b0;
                        mem_ack_q <= 1'b1;
                        mem_err_q <= 1'b1;
                        if (!we_q) mem_data_q <= dbl_q ? 16'hFFFF : 16'h00FF;
                        state_q   <= DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
                    end
                end
                HI: begin
                    if (mc.bus_ack) begin
                        bus_req_q <= 1'b0;
                        mem_ack_q <= 1'b1;
                        if (!we_q) mem_data_q <= {mc.bus_rdata, lo_q};
                        state_q   <= DONE;
                    end else if (wd_hit_d) begin
                        bus_req_q <= 1'b0;
                        mem_ack_q <= 1'b1;
                        mem_err_q <= 1'b1;
                        if (!we_q) mem_data_q <= 16'hFFFF;
                        state_q   <= DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    // Enables ignored here so the requester can retire its request
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mc.mem_data_in = mem_data_q;
    assign mc.mem_ack     = mem_ack_q;
    assign mc.mem_err     = mem_err_q;
    assign mc.bus_addr    = bus_addr_q;
    assign mc.bus_wdata   = bus_wdata_q;
    assign mc.bus_we      = bus_we_q;
    assign mc.bus_req     = bus_req_q;
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: scoreboard bench with a byte-wide device model (programmable wait states).
// Latency: measured in cycles from driving the enable to sampling mem_ack.
// Backpressure: device stretches bus_req by its wait-state count, or never acks when dead.
module tb_memory_controller;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    memory_controller_if mif();

    memory_controller #(.TIMEOUT(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .mc   (mif)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } xfer_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    xfer_t       exp_bus[$];
    rsp_t        exp_rsp[$];
    logic [7:0]  mem [0:65535];
    int          waits  = 0;
    int          wcnt   = 0;
    bit          dead   = 1'b0;
    int          cyc    = 0;
    int          t_ref  = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    bit          ack_now = 1'b0;
    logic [15:0] last_data = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_xfer(input logic [15:0] a, input logic we, input logic [7:0] d);
        xfer_t x;
        x.addr = a; x.we = we; x.data = d;
        exp_bus.push_back(x);
    endtask

    task automatic push_rsp(input logic [15:0] d, input logic err, input int lat);
        rsp_t r;
        r.data = d; r.err = err; r.lat = lat;
        exp_rsp.push_back(r);
        last_data = d;
    endtask

    // Expected bus traffic and response for a read that completes normally
    task automatic exp_read(input logic [15:0] a, input logic dbl, input int lat);
        logic [15:0] a1;
        a1 = a + 16'd1;
        push_xfer(a, 1'b0, 8'h00);
        if (dbl) begin
            push_xfer(a1, 1'b0, 8'h00);
            push_rsp({mem[a1], mem[a]}, 1'b0, lat);
        end else begin
            push_rsp({8'h00, mem[a]}, 1'b0, lat);
        end
    endtask

    task automatic exp_write(input logic [15:0] a, input logic [15:0] wd, input logic dbl, input int lat);
        logic [15:0] a1;
        a1 = a + 16'd1;
        push_xfer(a, 1'b1, wd[7:0]);
        if (dbl) push_xfer(a1, 1'b1, wd[15:8]);
        push_rsp(last_data, 1'b0, lat);
    endtask

    // One cycle: sample DUT outputs at the falling edge, check responses, then run the device model
    task automatic tick();
        rsp_t  r;
        xfer_t x;
        @(negedge clk);
        cyc++;
        ack_now = mif.mem_ack;
        if (nrst && mif.mem_ack) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_extra", 32'(exp_rsp.size()), 1);
            end else begin
                r = exp_rsp.pop_front();
                chk("rsp_data", mif.mem_data_in, r.data);
                chk("rsp_err", mif.mem_err, r.err);
                chk("rsp_lat", cyc - t_ref, r.lat);
                chk("rsp_req_low", mif.bus_req, 0);
            end
            t_ref = cyc;
        end else if (nrst && mif.mem_err) begin
            chk("err_wo_ack", mif.mem_err, 0);
        end
        if (nrst && mif.bus_req && !dead && wcnt == waits) begin
            if (exp_bus.size() == 0) begin
                chk("bus_extra", 32'(exp_bus.size()), 1);
            end else begin
                x = exp_bus.pop_front();
                chk("bus_addr", mif.bus_addr, x.addr);
                chk("bus_we", mif.bus_we, x.we);
                if (x.we) chk("bus_wdata", mif.bus_wdata, x.data);
            end
            mif.bus_rdata = mem[mif.bus_addr];
            if (mif.bus_we) mem[mif.bus_addr] = mif.bus_wdata;
            mif.bus_ack = 1'b1;
            wcnt = 0;
        end else begin
            mif.bus_ack = 1'b0;
            if (nrst && mif.bus_req) wcnt++;
            else wcnt = 0;
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] wd, input logic dbl,
                         input logic we, input logic re);
        mif.cpu_addr        = a;
        mif.cpu_wdata       = wd;
        mif.cpu_dbl_byte_en = dbl;
        mif.cpu_write_en    = we;
        mif.cpu_read_en     = re;
        t_ref               = cyc;
    endtask

    task automatic wait_ack(input bit drop);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack_now && n < 100);
        chk("ack_seen", ack_now, 1);
        if (drop) begin
            mif.cpu_write_en = 1'b0;
            mif.cpu_read_en  = 1'b0;
        end
    endtask

    initial begin
        nrst                = 1'b0;
        mif.cpu_addr        = '0;
        mif.cpu_wdata       = '0;
        mif.cpu_dbl_byte_en = 1'b0;
        mif.cpu_write_en    = 1'b0;
        mif.cpu_read_en     = 1'b0;
        mif.bus_rdata       = '0;
        mif.bus_ack         = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1000] = 8'h34;
        mem[16'h1001] = 8'h12;
        mem[16'h4000] = 8'h77;
        mem[16'h1234] = 8'h5A;

        // Reset state
        tick(); tick();
        chk("rst_data", mif.mem_data_in, 16'h0000);
        chk("rst_ack", mif.mem_ack, 0);
        chk("rst_err", mif.mem_err, 0);
        chk("rst_req", mif.bus_req, 0);
        chk("rst_addr", mif.bus_addr, 16'h0000);
        chk("rst_we", mif.bus_we, 0);
        chk("rst_wdata", mif.bus_wdata, 8'h00);
        nrst = 1'b1;
        tick();

        // Double-byte read, zero wait
        waits = 0;
        issue(16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1);
        exp_read(16'h1000, 1'b1, 3);
        wait_ack(1'b1);
        chk("rd16_value", mif.mem_data_in, 16'h1234);

        // Single-byte write, two wait states; read data must not change
        tick();
        waits = 2;
        issue(16'h2000, 16'hABCD, 1'b0, 1'b1, 1'b0);
        exp_write(16'h2000, 16'hABCD, 1'b0, 4);
        wait_ack(1'b1);

        // Double-byte write straddling the address wrap
        tick();
        waits = 0;
        issue(16'hFFFF, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        exp_write(16'hFFFF, 16'hBEEF, 1'b1, 3);
        wait_ack(1'b1);
        tick();
        chk("hold_addr", mif.bus_addr, 16'h0000);
        chk("hold_req", mif.bus_req, 0);
        chk("hold_we", mif.bus_we, 1);

        // Read back across the wrap
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        push_xfer(16'hFFFF, 1'b0, 8'h00);
        push_xfer(16'h0000, 1'b0, 8'h00);
        push_rsp(16'hBEEF, 1'b0, 3);
        wait_ack(1'b1);

        // Watchdog on a dead device: double then single byte
        tick();
        dead = 1'b1;
        issue(16'h5000, 16'h0000, 1'b1, 1'b0, 1'b1);
        push_rsp(16'hFFFF, 1'b1, 18);
        wait_ack(1'b1);
        tick();
        issue(16'h5002, 16'h0000, 1'b0, 1'b0, 1'b1);
        push_rsp(16'h00FF, 1'b1, 18);
        wait_ack(1'b1);
        dead = 1'b0;

        // Both enables high: write takes priority
        tick();
        issue(16'h3000, 16'h0055, 1'b0, 1'b1, 1'b1);
        exp_write(16'h3000, 16'h0055, 1'b0, 2);
        wait_ack(1'b1);

        // Back-to-back held single-byte reads: one mem_ack every 3 cycles
        tick();
        issue(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1);
        exp_read(16'h4000, 1'b0, 2);
        exp_read(16'h4000, 1'b0, 3);
        exp_read(16'h4000, 1'b0, 3);
        wait_ack(1'b0);
        wait_ack(1'b0);
        wait_ack(1'b1);

        // Single-byte read with one wait state
        tick();
        waits = 1;
        issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
        exp_read(16'h1234, 1'b0, 3);
        wait_ack(1'b1);

        // Reset in the middle of the high byte of a double read
        tick();
        waits = 3;
        issue(16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1);
        push_xfer(16'h1000, 1'b0, 8'h00);
        for (int i = 0; i < 50 && !(mif.bus_req && mif.bus_addr == 16'h1001); i++) tick();
        chk("hi_reached", mif.bus_addr, 16'h1001);
        nrst = 1'b0;
        tick();
        chk("mid_rst_req", mif.bus_req, 0);
        chk("mid_rst_ack", mif.mem_ack, 0);
        chk("mid_rst_data", mif.mem_data_in, 16'h0000);
        mif.cpu_read_en = 1'b0;
        exp_bus.delete();
        last_data = 16'h0000;
        nrst = 1'b1;
        tick();
        chk("post_rst_ack", mif.mem_ack, 0);
        waits = 0;
        issue(16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1);
        exp_read(16'h1000, 1'b1, 3);
        wait_ack(1'b1);
        tick(); tick();
        chk("bus_drained", 32'(exp_bus.size()), 0);
        chk("rsp_drained", 32'(exp_rsp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
